// File: rtl/hit_detector_if.sv
// Video stream bundle shared by the hit_detector input and output sides.
// master drives the stream, slave consumes it.
interface hit_detector_if;
  logic [11:0] hcount;
  logic [11:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport master (
    output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb
  );

  modport slave (
    input hcount, vcount, hsync, vsync, hblnk, vblnk, rgb
  );
endinterface

// File: rtl/hit_detector.sv
// Player/obstacle collision stage: one player_hit pulse per frame, then an IFRAMES-frame cooldown.
// Optional blink of the player box during cooldown is enabled by defining HIT_FLASH_EN.
module hit_detector #(
  parameter int PLAYER_W     = 20,
  parameter int PLAYER_H     = 20,
  parameter int IFRAMES      = 60,
  parameter int FLASH_PERIOD = 4
) (
  input  logic           pclk,
  input  logic           rst,
  hit_detector_if.slave  vin,
  hit_detector_if.master vout,
  input  logic           obstacle_pix,
  input  logic [11:0]    player_x,
  input  logic [11:0]    player_y,
  input  logic           game_on,
  output logic           player_hit,
  output logic           invuln
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    COOL  = 2'd2
  } state_t;

  localparam logic [7:0] IFRAMES_C = 8'(IFRAMES);

  if (PLAYER_W < 1 || PLAYER_W > 255 || PLAYER_H < 1 || PLAYER_H > 255 ||
      IFRAMES < 1 || IFRAMES > 255 || FLASH_PERIOD < 2 || FLASH_PERIOD > 64 ||
      (FLASH_PERIOD & (FLASH_PERIOD - 1)) != 0) begin : g_bad_params
    $error("hit_detector: parameter out of range");
  end

  state_t      state_r;
  state_t      state_nxt_s;
  logic [7:0]  cooldown_r;
  logic [7:0]  cooldown_nxt_s;
  logic        coll_seen_r;
  logic        coll_seen_nxt_s;
  logic        vblnk_d_r;
  logic        hit_nxt_s;
  logic [12:0] x_end_s;
  logic [12:0] y_end_s;
  logic        in_box_s;
  logic        coll_pix_s;
  logic        fb_s;
  logic [11:0] rgb_nxt_s;

  // 13-bit box ends so a box near the right/bottom edge clips instead of wrapping
  assign x_end_s    = {1'b0, player_x} + 13'(PLAYER_W);
  assign y_end_s    = {1'b0, player_y} + 13'(PLAYER_H);
  assign in_box_s   = (vin.hcount >= player_x) && ({1'b0, vin.hcount} < x_end_s) &&
                      (vin.vcount >= player_y) && ({1'b0, vin.vcount} < y_end_s);
  assign coll_pix_s = in_box_s && obstacle_pix && !vin.hblnk && !vin.vblnk;
  assign fb_s       = vin.vblnk && !vblnk_d_r;

`ifdef HIT_FLASH_EN
  localparam int FLASH_BIT = $clog2(FLASH_PERIOD);
  logic flash_s;

  // Blank the player box on odd blink phases while invulnerable
  assign flash_s   = (state_r == COOL) && in_box_s && !vin.hblnk && !vin.vblnk &&
                     cooldown_r[FLASH_BIT];
  assign rgb_nxt_s = flash_s ? 12'h000 : vin.rgb;
`else
  assign rgb_nxt_s = vin.rgb;
`endif

  // Next-state, cooldown, sticky collision flag and hit request
  always_comb begin
    state_nxt_s     = state_r;
    cooldown_nxt_s  = cooldown_r;
    coll_seen_nxt_s = coll_seen_r;
    hit_nxt_s       = 1'b0;
    if (!game_on) begin
      state_nxt_s     = IDLE;
      cooldown_nxt_s  = 8'd0;
      coll_seen_nxt_s = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          state_nxt_s     = ARMED;
          cooldown_nxt_s  = 8'd0;
          coll_seen_nxt_s = 1'b0;
        end
        ARMED: begin
          if (fb_s) begin
            coll_seen_nxt_s = 1'b0;
            if (coll_seen_r) begin
              hit_nxt_s      = 1'b1;
              cooldown_nxt_s = IFRAMES_C;
              state_nxt_s    = COOL;
            end else begin
              state_nxt_s = ARMED;
            end
          end else if (coll_pix_s) begin
            coll_seen_nxt_s = 1'b1;
          end else begin
            coll_seen_nxt_s = coll_seen_r;
          end
        end
        COOL: begin
          // collisions are ignored while invulnerable
          coll_seen_nxt_s = 1'b0;
          if (fb_s) begin
            if (cooldown_r <= 8'd1) begin
              cooldown_nxt_s = 8'd0;
              state_nxt_s    = ARMED;
            end else begin
              cooldown_nxt_s = cooldown_r - 8'd1;
              state_nxt_s    = COOL;
            end
          end else begin
            cooldown_nxt_s = cooldown_r;
          end
        end
        default: begin
          state_nxt_s     = IDLE;
          cooldown_nxt_s  = 8'd0;
          coll_seen_nxt_s = 1'b0;
        end
      endcase
    end
  end

  // Control state and frame-edge history
  always_ff @(posedge pclk) begin
    if (!rst) begin
      state_r     <= IDLE;
      cooldown_r  <= 8'd0;
      coll_seen_r <= 1'b0;
      vblnk_d_r   <= 1'b0;
      player_hit  <= 1'b0;
      invuln      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cooldown_r  <= cooldown_nxt_s;
      coll_seen_r <= coll_seen_nxt_s;
      vblnk_d_r   <= vin.vblnk;
      player_hit  <= hit_nxt_s;
      invuln      <= (state_nxt_s == COOL);
    end
  end

  // One-cycle video pass-through
  always_ff @(posedge pclk) begin
    if (!rst) begin
      vout.hcount <= 12'd0;
      vout.vcount <= 12'd0;
      vout.hsync  <= 1'b0;
      vout.vsync  <= 1'b0;
      vout.hblnk  <= 1'b0;
      vout.vblnk  <= 1'b0;
      vout.rgb    <= 12'h000;
    end else begin
      vout.hcount <= vin.hcount;
      vout.vcount <= vin.vcount;
      vout.hsync  <= vin.hsync;
      vout.vsync  <= vin.vsync;
      vout.hblnk  <= vin.hblnk;
      vout.vblnk  <= vin.vblnk;
      vout.rgb    <= rgb_nxt_s;
    end
  end

endmodule

// File: tb/tb_hit_detector.sv
// Directed bench for hit_detector: reset, pass-through, hit/cooldown sequencing, box edges, abort.
// With HIT_FLASH_EN defined it also checks the cooldown blink.
module tb_hit_detector;
  localparam int IFR = `ifdef HIT_FLASH_EN 6 `else 3 `endif;
  localparam logic [11:0] RGB_BG = 12'h5A5;

  logic        pclk = 1'b0;
  logic        rst  = 1'b0;
  logic        obstacle_pix;
  logic [11:0] player_x;
  logic [11:0] player_y;
  logic        game_on;
  logic        player_hit;
  logic        invuln;
  int          total = 0;
  int          bad   = 0;

  hit_detector_if vin ();
  hit_detector_if vout ();

  always #5 pclk = ~pclk;

  hit_detector #(
    .PLAYER_W    (20),
    .PLAYER_H    (20),
    .IFRAMES     (IFR),
    .FLASH_PERIOD(4)
  ) dut (
    .pclk        (pclk),
    .rst         (rst),
    .vin         (vin),
    .vout        (vout),
    .obstacle_pix(obstacle_pix),
    .player_x    (player_x),
    .player_y    (player_y),
    .game_on     (game_on),
    .player_hit  (player_hit),
    .invuln      (invuln)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one pixel, clock it in, return #1 after the edge
  task automatic step(input logic [11:0] hc, input logic [11:0] vc,
                      input logic hb, input logic vb, input logic obs);
    vin.hcount   = hc;
    vin.vcount   = vc;
    vin.hblnk    = hb;
    vin.vblnk    = vb;
    obstacle_pix = obs;
    @(posedge pclk);
    #1;
  endtask

  // Vertical blank: h1 = player_hit right after the fb edge, h2 = one cycle later
  task automatic frame_end(output logic h1, output logic h2, output logic iv);
    step(12'd0, 12'd0, 1'b0, 1'b1, 1'b0);
    h1 = player_hit;
    iv = invuln;
    step(12'd0, 12'd0, 1'b0, 1'b1, 1'b0);
    h2 = player_hit;
    step(12'd0, 12'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic h1, h2, iv;
    int   k, kp, cd;
    logic [11:0] exp_rgb;

    vin.hsync = 1'b0;
    vin.vsync = 1'b0;
    vin.rgb   = RGB_BG;
    player_x  = 12'd100;
    player_y  = 12'd100;
    game_on   = 1'b0;

    // reset with random inputs
    for (int i = 0; i < 3; i++) begin
      vin.hsync = 1'($urandom);
      vin.vsync = 1'($urandom);
      vin.rgb   = 12'($urandom);
      player_x  = 12'($urandom);
      player_y  = 12'($urandom);
      game_on   = 1'($urandom);
      step(12'($urandom), 12'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      chk("rst_hit", player_hit, 1'b0);
      chk("rst_inv", invuln, 1'b0);
      chk("rst_rgb", vout.rgb, 12'h000);
    end
    chk("rst_hcount", vout.hcount, 12'd0);
    chk("rst_vcount", vout.vcount, 12'd0);
    chk("rst_timing", {vout.hsync, vout.vsync, vout.hblnk, vout.vblnk}, 4'b0000);

    vin.hsync = 1'b0;
    vin.vsync = 1'b0;
    vin.rgb   = RGB_BG;
    player_x  = 12'd100;
    player_y  = 12'd100;
    game_on   = 1'b0;
    rst       = 1'b1;

    // collision while game_on=0 must not hit
    step(12'd105, 12'd110, 1'b0, 1'b0, 1'b1);
    frame_end(h1, h2, iv);
    chk("idle_hit", h1, 1'b0);
    chk("idle_inv", iv, 1'b0);

    // pass-through
    vin.hsync = 1'b1;
    vin.rgb   = 12'hABC;
    step(12'h123, 12'h045, 1'b1, 1'b0, 1'b0);
    chk("pt_hcount", vout.hcount, 12'h123);
    chk("pt_vcount", vout.vcount, 12'h045);
    chk("pt_sync", {vout.hsync, vout.vsync}, 2'b10);
    chk("pt_blnk", {vout.hblnk, vout.vblnk}, 2'b10);
    chk("pt_rgb", vout.rgb, 12'hABC);
    vin.hsync = 1'b0;
    vin.rgb   = RGB_BG;

    // single hit
    game_on = 1'b1;
    step(12'd0, 12'd0, 1'b0, 1'b0, 1'b0);
    step(12'd105, 12'd110, 1'b0, 1'b0, 1'b1);
    step(12'd106, 12'd110, 1'b0, 1'b0, 1'b0);
    chk("pre_fb_hit", player_hit, 1'b0);
    frame_end(h1, h2, iv);
    chk("single_hit", h1, 1'b1);
    chk("single_width", h2, 1'b0);
    chk("single_inv", iv, 1'b1);

`ifdef HIT_FLASH_EN
    // cooldown=6: 6/4 is odd, so the box is black
    step(12'd110, 12'd110, 1'b0, 1'b0, 1'b0);
    chk("flash_black", vout.rgb, 12'h000);
    step(12'd50, 12'd50, 1'b0, 1'b0, 1'b0);
    chk("flash_outside", vout.rgb, RGB_BG);
    step(12'd110, 12'd110, 1'b1, 1'b0, 1'b0);
    chk("flash_hblnk", vout.rgb, RGB_BG);
`endif

    // obstacle overlapping every frame: hits every IFR+1 boundaries
    for (int n = 2; n <= 2 * (IFR + 1) + 1; n++) begin
      kp = (n - 1) % (IFR + 1);
      cd = (kp == 0) ? 0 : IFR - (kp - 1);
      step(12'd105, 12'd110, 1'b0, 1'b0, 1'b1);
`ifdef HIT_FLASH_EN
      exp_rgb = (kp != 0 && ((cd / 4) % 2) == 1) ? 12'h000 : RGB_BG;
      chk("cool_flash", vout.rgb, exp_rgb);
`else
      exp_rgb = RGB_BG;
      chk("cool_rgb", vout.rgb, exp_rgb);
`endif
      frame_end(h1, h2, iv);
      k = n % (IFR + 1);
      chk("cool_hit", h1, (k == 1) ? 1'b1 : 1'b0);
      chk("cool_width", h2, 1'b0);
      chk("cool_inv", iv, (k != 0) ? 1'b1 : 1'b0);
    end

    // let the cooldown expire with no obstacle
    for (int i = 0; i < IFR; i++) begin
      step(12'd105, 12'd110, 1'b0, 1'b0, 1'b0);
      frame_end(h1, h2, iv);
      chk("recover_hit", h1, 1'b0);
    end
    chk("recover_inv", iv, 1'b0);

    // outside the box or blanked: no hit
    step(12'd99, 12'd100, 1'b0, 1'b0, 1'b1);
    step(12'd105, 12'd110, 1'b1, 1'b0, 1'b1);
    step(12'd120, 12'd105, 1'b0, 1'b0, 1'b1);
    step(12'd105, 12'd120, 1'b0, 1'b0, 1'b1);
    step(12'd105, 12'd99, 1'b0, 1'b0, 1'b1);
    frame_end(h1, h2, iv);
    chk("outside_hit", h1, 1'b0);
    chk("outside_inv", iv, 1'b0);

    // last pixel inside the box does hit
    step(12'd119, 12'd119, 1'b0, 1'b0, 1'b1);
    frame_end(h1, h2, iv);
    chk("edge_hit", h1, 1'b1);
    chk("edge_inv", iv, 1'b1);

    // reset during cooldown
    rst = 1'b0;
    step(12'd0, 12'd0, 1'b0, 1'b0, 1'b0);
    chk("rst_cool_inv", invuln, 1'b0);
    chk("rst_cool_hit", player_hit, 1'b0);
    rst = 1'b1;

    // game_on falls on the same edge as a qualifying fb
    step(12'd0, 12'd0, 1'b0, 1'b0, 1'b0);
    step(12'd105, 12'd110, 1'b0, 1'b0, 1'b1);
    game_on = 1'b0;
    frame_end(h1, h2, iv);
    chk("abort_hit", h1, 1'b0);
    chk("abort_hit2", h2, 1'b0);
    chk("abort_inv", iv, 1'b0);

    // the dropped collision must not resurface
    game_on = 1'b1;
    step(12'd0, 12'd0, 1'b0, 1'b0, 1'b0);
    frame_end(h1, h2, iv);
    chk("abort_drop_hit", h1, 1'b0);
    chk("abort_drop_inv", iv, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
